// File: rtl/corr_ctrl_pkg.sv
// Shared state encoding and dump word indices for the single-bin dump controller.
package corr_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    WAIT = 2'd2,
    SEND = 2'd3
  } state_t;

  localparam logic [1:0] PWR0    = 2'd0;
  localparam logic [1:0] PWR1    = 2'd1;
  localparam logic [1:0] CORR_RE = 2'd2;
  localparam logic [1:0] CORR_IM = 2'd3;

endpackage

// File: rtl/dump_serializer.sv
// Beat counter and word-select mux turning a four-word snapshot into a stream.
module dump_serializer
  import corr_ctrl_pkg::*;
#(
  parameter int DOUT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  advance,
  input  logic                  tvalid,
  input  logic [DOUT_WIDTH-1:0] snap_pwr0,
  input  logic [DOUT_WIDTH-1:0] snap_pwr1,
  input  logic [DOUT_WIDTH-1:0] snap_re,
  input  logic [DOUT_WIDTH-1:0] snap_im,
  output logic [DOUT_WIDTH-1:0] tdata,
  output logic [1:0]            tuser,
  output logic                  tlast
);

  logic [1:0] beat;

  // load wins over advance so a back-to-back capture restarts at word 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat <= PWR0;
    end else if (load) begin
      beat <= PWR0;
    end else if (advance) begin
      beat <= beat + 2'd1;
    end
  end

  always_comb begin
    tdata = snap_pwr0;
    case (beat)
      PWR0:    tdata = snap_pwr0;
      PWR1:    tdata = snap_pwr1;
      CORR_RE: tdata = snap_re;
      CORR_IM: tdata = snap_im;
      default: tdata = snap_pwr0;
    endcase
  end

  assign tuser = beat;
  assign tlast = tvalid && (beat == CORR_IM);

endmodule

// File: rtl/single_bin_dump_ctrl.sv
// Captures correlator integrations for one bin and streams each as a 4-word frame.
//   state | meaning
//   IDLE  | disarmed, corr_valid ignored
//   SYNC  | armed, discarding the partial first integration
//   WAIT  | waiting for the next completed integration
//   SEND  | streaming the snapshot, beats 0..3
module single_bin_dump_ctrl
  import corr_ctrl_pkg::*;
#(
  parameter int DOUT_WIDTH = 32,
  parameter int OVR_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         stop,
  input  logic [31:0]                  n_integ,
  input  logic signed [DOUT_WIDTH-1:0] correlation_re,
  input  logic signed [DOUT_WIDTH-1:0] correlation_im,
  input  logic [DOUT_WIDTH-1:0]        power0,
  input  logic [DOUT_WIDTH-1:0]        power1,
  input  logic                         corr_valid,
  output logic [DOUT_WIDTH-1:0]        m_tdata,
  output logic                         m_tvalid,
  output logic                         m_tlast,
  output logic [1:0]                   m_tuser,
  input  logic                         m_tready,
  output logic [31:0]                  integ_count,
  output logic [OVR_WIDTH-1:0]         overrun_count,
  output logic                         busy,
  output logic                         done
);

  localparam logic [OVR_WIDTH-1:0] OVR_ONE = {{(OVR_WIDTH-1){1'b0}}, 1'b1};

  state_t                state;
  logic                  stop_pend;
  logic [DOUT_WIDTH-1:0] snap_pwr0, snap_pwr1, snap_re, snap_im;
  logic                  accept, last_accept, run_end, capture;

  assign accept      = m_tvalid && m_tready;
  assign last_accept = accept && m_tlast;
  // a stop arriving with the final beat ends the run just like a pending one
  assign run_end     = ((n_integ != 32'd0) && (integ_count == n_integ)) || stop_pend || stop;
  assign capture     = corr_valid &&
                       (((state == WAIT) && !stop) ||
                        ((state == SEND) && last_accept && !run_end));
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      stop_pend     <= 1'b0;
      integ_count   <= 32'd0;
      overrun_count <= '0;
      m_tvalid      <= 1'b0;
      done          <= 1'b0;
      snap_pwr0     <= '0;
      snap_pwr1     <= '0;
      snap_re       <= '0;
      snap_im       <= '0;
    end else begin
      done <= 1'b0;
      if (capture) begin
        snap_pwr0   <= power0;
        snap_pwr1   <= power1;
        snap_re     <= correlation_re;
        snap_im     <= correlation_im;
        integ_count <= integ_count + 32'd1;
      end
      case (state)
        IDLE: begin
          if (start && !stop) begin
            state         <= SYNC;
            integ_count   <= 32'd0;
            overrun_count <= '0;
            stop_pend     <= 1'b0;
          end
        end
        SYNC: begin
          if (stop) begin
            state <= IDLE;
            done  <= 1'b1;
          end else if (corr_valid) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (stop) begin
            state <= IDLE;
            done  <= 1'b1;
          end else if (corr_valid) begin
            state    <= SEND;
            m_tvalid <= 1'b1;
          end
        end
        SEND: begin
          if (stop) stop_pend <= 1'b1;
          if (last_accept) begin
            if (run_end) begin
              state     <= IDLE;
              m_tvalid  <= 1'b0;
              done      <= 1'b1;
              stop_pend <= 1'b0;
            end else if (!corr_valid) begin
              state    <= WAIT;
              m_tvalid <= 1'b0;
            end
          end else if (corr_valid && (overrun_count != '1)) begin
            overrun_count <= overrun_count + OVR_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  dump_serializer #(.DOUT_WIDTH(DOUT_WIDTH)) u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (capture),
    .advance   (accept),
    .tvalid    (m_tvalid),
    .snap_pwr0 (snap_pwr0),
    .snap_pwr1 (snap_pwr1),
    .snap_re   (snap_re),
    .snap_im   (snap_im),
    .tdata     (m_tdata),
    .tuser     (m_tuser),
    .tlast     (m_tlast)
  );

endmodule

// File: tb/tb_single_bin_dump_ctrl.sv
// Scoreboard bench for single_bin_dump_ctrl; a 2-bit overrun twin checks saturation.
module tb_single_bin_dump_ctrl;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst, start, stop, corr_valid, m_tready;
  logic [31:0] n_integ;
  logic signed [W-1:0] cre, cim;
  logic [W-1:0] p0, p1;

  logic [W-1:0]  m_tdata;
  logic          m_tvalid, m_tlast, busy, done;
  logic [1:0]    m_tuser;
  logic [31:0]   integ_count;
  logic [15:0]   overrun_count;

  logic [W-1:0]  d2_tdata;
  logic          d2_tvalid, d2_tlast, d2_busy, d2_done;
  logic [1:0]    d2_tuser;
  logic [31:0]   d2_integ;
  logic [1:0]    d2_overrun;

  single_bin_dump_ctrl #(.DOUT_WIDTH(W), .OVR_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .n_integ(n_integ),
    .correlation_re(cre), .correlation_im(cim), .power0(p0), .power1(p1),
    .corr_valid(corr_valid), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
    .m_tlast(m_tlast), .m_tuser(m_tuser), .m_tready(m_tready),
    .integ_count(integ_count), .overrun_count(overrun_count),
    .busy(busy), .done(done)
  );

  single_bin_dump_ctrl #(.DOUT_WIDTH(W), .OVR_WIDTH(2)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .n_integ(n_integ),
    .correlation_re(cre), .correlation_im(cim), .power0(p0), .power1(p1),
    .corr_valid(corr_valid), .m_tdata(d2_tdata), .m_tvalid(d2_tvalid),
    .m_tlast(d2_tlast), .m_tuser(d2_tuser), .m_tready(m_tready),
    .integ_count(d2_integ), .overrun_count(d2_overrun),
    .busy(d2_busy), .done(d2_done)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  int done_cnt = 0;
  int d0;
  logic [34:0] sb[$];
  logic [34:0] exp_beat;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (done) done_cnt++;
      if (m_tvalid && m_tready) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", 64'(m_tvalid), 64'd0);
        end else begin
          exp_beat = sb.pop_front();
          chk("beat", 64'({m_tlast, m_tuser, m_tdata}), 64'(exp_beat));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cv(input bit capture);
    p0  = $urandom;
    p1  = $urandom;
    cre = $urandom;
    cim = $urandom;
    corr_valid = 1'b1;
    if (capture) begin
      sb.push_back({1'b0, 2'd0, p0});
      sb.push_back({1'b0, 2'd1, p1});
      sb.push_back({1'b0, 2'd2, cre});
      sb.push_back({1'b1, 2'd3, cim});
    end
    tick();
    corr_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) tick();
    chk("drain_empty", 64'(sb.size()), 64'd0);
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; corr_valid = 1'b0; m_tready = 1'b1;
    n_integ = 32'd0; p0 = '0; p1 = '0; cre = '0; cim = '0;
    #12;
    chk("rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_tuser", 64'(m_tuser), 64'd0);
    chk("rst_tlast", 64'(m_tlast), 64'd0);
    chk("rst_integ", 64'(integ_count), 64'd0);
    chk("rst_ovr", 64'(overrun_count), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // basic run of two integrations
    n_integ = 32'd2;
    d0 = done_cnt;
    pulse_start();
    chk("basic_busy", 64'(busy), 64'd1);
    cv(1'b0);
    tick();
    cv(1'b1);
    drain();
    chk("basic_wait_busy", 64'(busy), 64'd1);
    cv(1'b1);
    drain();
    chk("basic_integ", 64'(integ_count), 64'd2);
    chk("basic_idle", 64'(busy), 64'd0);
    chk("basic_done", 64'(done_cnt - d0), 64'd1);

    // backpressure at beat 1
    n_integ = 32'd1;
    d0 = done_cnt;
    pulse_start();
    cv(1'b0);
    tick();
    cv(1'b1);
    tick();
    m_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(m_tvalid), 64'd1);
      chk("bp_user", 64'(m_tuser), 64'd1);
      chk("bp_data", 64'(m_tdata), 64'(p1));
      tick();
    end
    m_tready = 1'b1;
    drain();
    chk("bp_integ", 64'(integ_count), 64'd1);
    chk("bp_idle", 64'(busy), 64'd0);
    chk("bp_done", 64'(done_cnt - d0), 64'd1);

    // overrun and saturation, then stop in WAIT
    n_integ = 32'd0;
    d0 = done_cnt;
    pulse_start();
    cv(1'b0);
    tick();
    m_tready = 1'b0;
    cv(1'b1);
    for (int i = 1; i <= 5; i++) begin
      cv(1'b0);
      tick();
      if (i == 3) begin
        chk("ovr_3", 64'(overrun_count), 64'd3);
        chk("ovr_sat_3", 64'(d2_overrun), 64'd3);
      end
    end
    chk("ovr_5", 64'(overrun_count), 64'd5);
    chk("ovr_sat_5", 64'(d2_overrun), 64'd3);
    m_tready = 1'b1;
    drain();
    chk("ovr_wait_busy", 64'(busy), 64'd1);
    pulse_stop();
    chk("stop_wait_idle", 64'(busy), 64'd0);
    chk("stop_wait_done", 64'(done), 64'd1);
    tick();
    chk("stop_wait_done_cnt", 64'(done_cnt - d0), 64'd1);

    // back-to-back capture on final beat acceptance
    pulse_start();
    chk("b2b_ovr_clr", 64'(overrun_count), 64'd0);
    cv(1'b0);
    tick();
    cv(1'b1);
    tick();
    tick();
    tick();
    chk("b2b_beat3", 64'(m_tuser), 64'd3);
    cv(1'b1);
    chk("b2b_valid", 64'(m_tvalid), 64'd1);
    chk("b2b_user0", 64'(m_tuser), 64'd0);
    chk("b2b_ovr", 64'(overrun_count), 64'd0);
    drain();
    chk("b2b_integ", 64'(integ_count), 64'd2);

    // stop at beat 1 of a free-run frame
    d0 = done_cnt;
    cv(1'b1);
    tick();
    chk("stop_send_beat1", 64'(m_tuser), 64'd1);
    pulse_stop();
    chk("stop_send_busy", 64'(busy), 64'd1);
    drain();
    chk("stop_send_idle", 64'(busy), 64'd0);
    chk("stop_send_done", 64'(done_cnt - d0), 64'd1);
    chk("stop_send_integ", 64'(integ_count), 64'd3);

    // start and stop together in IDLE
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    chk("start_stop_idle", 64'(busy), 64'd0);

    // reset mid-frame at beat 2
    pulse_start();
    cv(1'b0);
    tick();
    cv(1'b1);
    tick();
    tick();
    chk("rst_mid_beat2", 64'(m_tuser), 64'd2);
    rst = 1'b1;
    #1;
    chk("rst_mid_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_mid_integ", 64'(integ_count), 64'd0);
    chk("rst_mid_ovr", 64'(overrun_count), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    sb.delete();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("rst_after_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_after_busy", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/single_bin_dump_ctrl.md
SINGLE_BIN_DUMP_CTRL -- requirements
Module: single_bin_dump_ctrl

Interface
REQ-001 SHALL have parameter DOUT_WIDTH, default 32: width of each accumulated correlator word and of m_tdata.
REQ-002 SHALL have parameter OVR_WIDTH, default 16: width of the saturating overrun counter.
REQ-003 SHALL have port clk  input  1  the only clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port start  input  1  single-cycle pulse that arms a capture run.
REQ-006 SHALL have port stop  input  1  single-cycle pulse that ends a run.
REQ-007 SHALL have port n_integ  input  32  number of integrations to capture; 0 means free-run.
REQ-008 SHALL have ports correlation_re, correlation_im  input  DOUT_WIDTH signed  cross product from the correlator accumulator.
REQ-009 SHALL have ports power0, power1  input  DOUT_WIDTH unsigned  auto products from the correlator accumulator.
REQ-010 SHALL have port corr_valid  input  1  one-cycle strobe marking a completed integration on the four data inputs.
REQ-011 SHALL have ports m_tdata (DOUT_WIDTH), m_tvalid (1), m_tlast (1) and m_tuser (2)  output  stream of dump words; m_tuser carries the word index.
REQ-012 SHALL have port m_tready  input  1  downstream ready.
REQ-013 SHALL have ports integ_count (32), overrun_count (OVR_WIDTH), busy (1) and done (1)  output  status.

Function
REQ-014 SHALL implement the states IDLE, SYNC, WAIT and SEND.
REQ-015 In IDLE, corr_valid SHALL be ignored; on start, integ_count and overrun_count SHALL clear and the state SHALL go to SYNC.
REQ-016 In SYNC, the first corr_valid SHALL be discarded (it closes a partial integration) and the state SHALL go to WAIT.
REQ-017 In WAIT, corr_valid SHALL latch all four inputs into a snapshot register, increment integ_count and go to SEND in the next cycle.
REQ-018 m_tvalid SHALL be asserted one cycle after the capturing corr_valid.
REQ-019 In SEND, SHALL emit four beats in the order power0, power1, correlation_re, correlation_im, with m_tuser 0,1,2,3.
REQ-020 m_tlast SHALL be high on beat 3 only.
REQ-021 A beat SHALL advance only when m_tvalid and m_tready are both high; m_tdata, m_tuser and m_tlast SHALL stay stable while stalled.
REQ-022 A corr_valid during SEND that does not coincide with acceptance of beat 3 SHALL be dropped and SHALL increment overrun_count, saturating at all-ones.
REQ-023 A corr_valid in the same cycle as acceptance of beat 3 SHALL be captured and SEND SHALL restart at beat 0 with no idle cycle, unless the run ends per REQ-024.
REQ-024 After acceptance of beat 3, if n_integ != 0 and integ_count == n_integ, or if a stop is pending, the state SHALL return to IDLE and done SHALL pulse for 1 cycle; otherwise the state SHALL return to WAIT.
REQ-025 stop in SYNC or WAIT SHALL return the state to IDLE immediately and pulse done.
REQ-026 stop in SEND SHALL set a pending flag; the frame in progress SHALL always complete.
REQ-027 start outside IDLE SHALL be ignored.
REQ-028 start and stop in the same cycle in IDLE SHALL leave the state in IDLE.
REQ-029 busy SHALL be high in every state except IDLE.
REQ-030 integ_count SHALL wrap modulo 2^32 in free-run mode.

Reset
REQ-031 rst SHALL force the state to IDLE, clear all counters, the snapshot register and the stop-pending flag, and drive m_tvalid, m_tlast, m_tuser, done and busy to 0, asynchronously.
REQ-032 rst mid-frame SHALL abandon the frame; no further beat SHALL be emitted until a new start.

Structure
REQ-033 The state encoding and the word-index constants (PWR0=0, PWR1=1, CORR_RE=2, CORR_IM=3) SHALL live in a shared package, corr_ctrl_pkg.
REQ-034 The word-select mux plus beat counter SHALL be one sub-module, dump_serializer; all other logic SHALL be in the top module.

Verification
REQ-035 The bench SHALL cover the basic run: n_integ=2, start, corr_valid pulses #1 (discarded), #2 and #3 with m_tready=1 -> two 4-beat frames, integ_count=2, done pulses once, state ends in IDLE.
REQ-036 The bench SHALL cover backpressure: m_tready low for 5 cycles at beat 1 -> beat 1 data held stable, sequence unchanged, no loss.
REQ-037 The bench SHALL cover overrun: with m_tready=0, 3 corr_valid during SEND -> overrun_count=3; with OVR_WIDTH=2 and 5 overruns -> overrun_count=3 (saturated).
REQ-038 The bench SHALL cover back-to-back: corr_valid coincident with acceptance of beat 3 -> next frame beat 0 on the following cycle, overrun_count unchanged.
REQ-039 The bench SHALL cover stop: stop at beat 1 of a free-run frame -> beats 2 and 3 still emitted, then IDLE and done pulses; stop in WAIT -> IDLE on the next cycle.
REQ-040 The bench SHALL cover reset: rst asserted at beat 2 -> m_tvalid=0 immediately, all counters 0, busy=0.
